// File: rtl/uart_rx_fifo_ctrl_if.sv
// Receiver-side and bus-side signals of the UART RX FIFO controller.
// The slave modport belongs to the controller; the master modport belongs to whoever drives it.
interface uart_rx_fifo_ctrl_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  baud_clock;
    logic                  rx_fifo_write_n;
    logic [7:0]            rx_byte;
    logic                  rx_parity_err;
    logic                  rx_framing_err;
    logic                  rx_stop_strobe;
    logic                  rx_idle;
    logic                  rx_clear_parity;
    logic                  rx_clear_framing_error;
    logic                  rd_req;
    logic [7:0]            rd_data;
    logic                  rd_parity_err;
    logic                  rd_framing_err;
    logic                  rd_valid;
    logic [DEPTH_LOG2:0]   irq_level;
    logic                  overflow_clr;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  rx_empty;
    logic                  rx_full;
    logic                  rx_overflow;
    logic                  rx_timeout;
    logic                  rx_irq;

    modport slave (
        input  baud_clock, rx_fifo_write_n, rx_byte, rx_parity_err, rx_framing_err,
        input  rx_stop_strobe, rx_idle, rd_req, irq_level, overflow_clr,
        output rx_clear_parity, rx_clear_framing_error, rd_data, rd_parity_err,
        output rd_framing_err, rd_valid, fifo_count, rx_empty, rx_full,
        output rx_overflow, rx_timeout, rx_irq
    );

    modport master (
        output baud_clock, rx_fifo_write_n, rx_byte, rx_parity_err, rx_framing_err,
        output rx_stop_strobe, rx_idle, rd_req, irq_level, overflow_clr,
        input  rx_clear_parity, rx_clear_framing_error, rd_data, rd_parity_err,
        input  rd_framing_err, rd_valid, fifo_count, rx_empty, rx_full,
        input  rx_overflow, rx_timeout, rx_irq
    );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// Stages each received byte until its stop bit resolves the framing flag, then commits
// {framing, parity, byte} into a FIFO with pop, fill status, overflow and timeout interrupt.
module uart_rx_fifo_ctrl #(
    parameter int DEPTH_LOG2      = 4,
    parameter int TIMEOUT_TICKS   = 640,
    parameter int STOP_WAIT_TICKS = 32
) (
    input logic                clk,
    input logic                reset_n,
    uart_rx_fifo_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW_W  = $clog2(STOP_WAIT_TICKS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [SW_W-1:0]       SW_MAX   = SW_W'(STOP_WAIT_TICKS);
    localparam logic [SW_W-1:0]       SW_ONE   = SW_W'(1);
    localparam logic [TO_W-1:0]       TO_MAX   = TO_W'(TIMEOUT_TICKS);
    localparam logic [TO_W-1:0]       TO_ONE   = TO_W'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_STOP, S_COMMIT} state_t;

    state_t                state_q, state_d;
    logic [7:0]            stg_byte_q, stg_byte_d;
    logic                  stg_par_q, stg_par_d;
    logic                  stg_frm_q, stg_frm_d;
    logic [SW_W-1:0]       stop_cnt_q, stop_cnt_d;
    logic                  clr_pulse;

    logic [9:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]            rd_data_q;
    logic                  rd_par_q, rd_frm_q, rd_valid_q;
    logic [TO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  overflow_q, overflow_d;
    logic                  irq_q, irq_d;

    logic fifo_empty, fifo_full, pop, wr_en, drop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign pop        = bus.rd_req && !fifo_empty;
    // A full FIFO still accepts the commit when a pop frees the head slot in the same clk.
    assign wr_en      = (state_q == S_COMMIT) && (!fifo_full || pop);
    assign drop       = ((state_q == S_COMMIT) && !wr_en)
                      || (!bus.rx_fifo_write_n && (state_q != S_IDLE));

    always_comb begin
        state_d    = state_q;
        stg_byte_d = stg_byte_q;
        stg_par_d  = stg_par_q;
        stg_frm_d  = stg_frm_q;
        stop_cnt_d = stop_cnt_q;
        clr_pulse  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!bus.rx_fifo_write_n) begin
                    stg_byte_d = bus.rx_byte;
                    stg_par_d  = bus.rx_parity_err;
                    stg_frm_d  = 1'b0;
                    stop_cnt_d = '0;
                    state_d    = S_WAIT_STOP;
                end
            end
            S_WAIT_STOP: begin
                if (bus.rx_framing_err) stg_frm_d = 1'b1;
                if (bus.baud_clock)     stop_cnt_d = stop_cnt_q + SW_ONE;
                if (bus.rx_stop_strobe) begin
                    state_d = S_COMMIT;
                end else if (stop_cnt_d == SW_MAX) begin
                    stg_frm_d = 1'b1;
                    state_d   = S_COMMIT;
                end
            end
            S_COMMIT: begin
                clr_pulse = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop)      count_d = count_q + CNT_ONE;
        else if (!wr_en && pop) count_d = count_q - CNT_ONE;

        tmo_cnt_d = tmo_cnt_q;
        if (wr_en || pop || fifo_empty)
            tmo_cnt_d = '0;
        else if (bus.baud_clock && bus.rx_idle && (state_q == S_IDLE) && (tmo_cnt_q != TO_MAX))
            tmo_cnt_d = tmo_cnt_q + TO_ONE;

        timeout_d = timeout_q;
        if (pop || fifo_empty)       timeout_d = 1'b0;
        else if (tmo_cnt_q == TO_MAX) timeout_d = 1'b1;

        overflow_d = overflow_q;
        if (drop)                  overflow_d = 1'b1;
        else if (bus.overflow_clr) overflow_d = 1'b0;

        irq_d = ((bus.irq_level != '0) && (count_d >= bus.irq_level)) || timeout_d || overflow_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            stg_byte_q <= '0;
            stg_par_q  <= 1'b0;
            stg_frm_q  <= 1'b0;
            stop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_par_q   <= 1'b0;
            rd_frm_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            tmo_cnt_q  <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stg_byte_q <= stg_byte_d;
            stg_par_q  <= stg_par_d;
            stg_frm_q  <= stg_frm_d;
            stop_cnt_q <= stop_cnt_d;
            count_q    <= count_d;
            tmo_cnt_q  <= tmo_cnt_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
            rd_valid_q <= pop;
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                {rd_frm_q, rd_par_q, rd_data_q} <= mem[rd_ptr_q];
            end
        end
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {stg_frm_q, stg_par_q, stg_byte_q};
    end

    assign bus.rx_clear_parity        = clr_pulse;
    assign bus.rx_clear_framing_error = clr_pulse;
    assign bus.rd_data                = rd_data_q;
    assign bus.rd_parity_err          = rd_par_q;
    assign bus.rd_framing_err         = rd_frm_q;
    assign bus.rd_valid               = rd_valid_q;
    assign bus.fifo_count             = count_q;
    assign bus.rx_empty               = fifo_empty;
    assign bus.rx_full                = fifo_full;
    assign bus.rx_overflow            = overflow_q;
    assign bus.rx_timeout             = timeout_q;
    assign bus.rx_irq                 = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl: a vector table for single-byte commit/pop,
// plus hand-written sequences for overflow, full+pop, timeout, threshold and reset.
module tb_uart_rx_fifo_ctrl;
    localparam int DL2 = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_ctrl_if #(.DEPTH_LOG2(DL2)) ifc ();

    uart_rx_fifo_ctrl #(
        .DEPTH_LOG2(DL2), .TIMEOUT_TICKS(640), .STOP_WAIT_TICKS(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(ifc)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       frm;
        logic [7:0] exp_data;
        logic       exp_par;
        logic       exp_frm;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int clrp_cnt = 0;
    int clrf_cnt = 0;

    always @(negedge clk) begin
        if (ifc.rx_clear_parity)        clrp_cnt++;
        if (ifc.rx_clear_framing_error) clrf_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.baud_clock = 1'b1; step();
            ifc.baud_clock = 1'b0; step();
        end
    endtask

    // Strobe, optional framing pulse two clks before the stop strobe, then commit.
    task automatic send_byte(input logic [7:0] b, input logic par, input logic frm, input logic pop_in_commit);
        ifc.rx_byte = b; ifc.rx_parity_err = par; ifc.rx_fifo_write_n = 1'b0;
        step();
        ifc.rx_fifo_write_n = 1'b1; ifc.rx_parity_err = 1'b0;
        if (frm) begin
            ifc.rx_framing_err = 1'b1; step();
            ifc.rx_framing_err = 1'b0; step();
        end else begin
            step();
        end
        ifc.rx_stop_strobe = 1'b1; step();
        ifc.rx_stop_strobe = 1'b0; ifc.rd_req = pop_in_commit; step();
        ifc.rd_req = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic p, input logic f);
        ifc.rd_req = 1'b1; step();
        ifc.rd_req = 1'b0;
        chk({tag, " rd_valid"}, 32'(ifc.rd_valid), 32'(1'b1));
        chk({tag, " rd_data"}, 32'(ifc.rd_data), 32'(d));
        chk({tag, " rd_parity_err"}, 32'(ifc.rd_parity_err), 32'(p));
        chk({tag, " rd_framing_err"}, 32'(ifc.rd_framing_err), 32'(f));
        $display("pop %s: data=0x%02h par=%0b frm=%0b", tag, ifc.rd_data, ifc.rd_parity_err, ifc.rd_framing_err);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " fifo_count"}, 32'(ifc.fifo_count), 32'd0);
        chk({tag, " rx_empty"}, 32'(ifc.rx_empty), 32'd1);
        chk({tag, " rx_full"}, 32'(ifc.rx_full), 32'd0);
        chk({tag, " rx_overflow"}, 32'(ifc.rx_overflow), 32'd0);
        chk({tag, " rx_timeout"}, 32'(ifc.rx_timeout), 32'd0);
        chk({tag, " rx_irq"}, 32'(ifc.rx_irq), 32'd0);
        chk({tag, " rd_valid"}, 32'(ifc.rd_valid), 32'd0);
        chk({tag, " rd_data"}, 32'(ifc.rd_data), 32'd0);
        chk({tag, " rx_clear_parity"}, 32'(ifc.rx_clear_parity), 32'd0);
        $display("reset check %s done", tag);
    endtask

    vec_t vecs [6];

    initial begin
        int p0, f0;
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[2] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0};

        ifc.baud_clock = 1'b0; ifc.rx_fifo_write_n = 1'b1; ifc.rx_byte = '0;
        ifc.rx_parity_err = 1'b0; ifc.rx_framing_err = 1'b0; ifc.rx_stop_strobe = 1'b0;
        ifc.rx_idle = 1'b1; ifc.rd_req = 1'b0; ifc.irq_level = '0; ifc.overflow_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("initial");
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            p0 = clrp_cnt; f0 = clrf_cnt;
            send_byte(vecs[i].data, vecs[i].par, vecs[i].frm, 1'b0);
            chk("vec fifo_count after commit", 32'(ifc.fifo_count), 32'd1);
            chk("vec clear_parity pulse width", 32'(clrp_cnt - p0), 32'd1);
            chk("vec clear_framing pulse width", 32'(clrf_cnt - f0), 32'd1);
            pop_chk($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_par, vecs[i].exp_frm);
            chk("vec fifo_count after pop", 32'(ifc.fifo_count), 32'd0);
            step();
            chk("vec rd_valid one cycle", 32'(ifc.rd_valid), 32'd0);
            chk("vec rd_data holds", 32'(ifc.rd_data), 32'(vecs[i].exp_data));
        end

        // Pop while empty is ignored.
        ifc.rd_req = 1'b1; step(); ifc.rd_req = 1'b0;
        chk("empty pop rd_valid", 32'(ifc.rd_valid), 32'd0);
        chk("empty pop count", 32'(ifc.fifo_count), 32'd0);
        chk("empty pop rd_data", 32'(ifc.rd_data), 32'h81);
        $display("empty pop: rd_valid=%0b count=%0d", ifc.rd_valid, ifc.fifo_count);

        // Forced commit after STOP_WAIT_TICKS with no stop strobe.
        ifc.rx_byte = 8'h3C; ifc.rx_fifo_write_n = 1'b0; step(); ifc.rx_fifo_write_n = 1'b1;
        ticks(31);
        step(); step(); step();
        chk("forced commit not before 32 ticks", 32'(ifc.fifo_count), 32'd0);
        ticks(1);
        step(); step(); step();
        chk("forced commit after 32 ticks", 32'(ifc.fifo_count), 32'd1);
        pop_chk("forced", 8'h3C, 1'b0, 1'b1);

        // Strobe during WAIT_STOP: dropped, overflow set, staging kept.
        ifc.rx_byte = 8'h11; ifc.rx_parity_err = 1'b0; ifc.rx_fifo_write_n = 1'b0; step();
        ifc.rx_byte = 8'h22; ifc.rx_parity_err = 1'b1; step();
        ifc.rx_fifo_write_n = 1'b1; ifc.rx_parity_err = 1'b0;
        chk("late strobe overflow", 32'(ifc.rx_overflow), 32'd1);
        chk("late strobe irq", 32'(ifc.rx_irq), 32'd1);
        ifc.rx_stop_strobe = 1'b1; step(); ifc.rx_stop_strobe = 1'b0; step();
        chk("late strobe count", 32'(ifc.fifo_count), 32'd1);
        pop_chk("late strobe", 8'h11, 1'b0, 1'b0);
        ifc.overflow_clr = 1'b1; step(); ifc.overflow_clr = 1'b0;
        chk("overflow_clr", 32'(ifc.rx_overflow), 32'd0);
        chk("overflow_clr irq", 32'(ifc.rx_irq), 32'd0);

        // Fill past capacity.
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill count", 32'(ifc.fifo_count), 32'd16);
        chk("fill rx_full", 32'(ifc.rx_full), 32'd1);
        chk("fill rx_empty", 32'(ifc.rx_empty), 32'd0);
        chk("fill rx_overflow", 32'(ifc.rx_overflow), 32'd1);
        chk("fill rx_irq", 32'(ifc.rx_irq), 32'd1);
        $display("fill: count=%0d full=%0b ovf=%0b", ifc.fifo_count, ifc.rx_full, ifc.rx_overflow);
        ifc.overflow_clr = 1'b1; step(); ifc.overflow_clr = 1'b0;
        chk("fill overflow_clr", 32'(ifc.rx_overflow), 32'd0);

        // Commit into a full FIFO with a pop in the COMMIT clk.
        send_byte(8'h55, 1'b0, 1'b0, 1'b1);
        chk("full+pop rd_valid", 32'(ifc.rd_valid), 32'd1);
        chk("full+pop rd_data", 32'(ifc.rd_data), 32'h00);
        chk("full+pop count", 32'(ifc.fifo_count), 32'd16);
        chk("full+pop overflow", 32'(ifc.rx_overflow), 32'd0);
        $display("full+pop: data=0x%02h count=%0d", ifc.rd_data, ifc.fifo_count);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("drain%0d", i), 8'(i), 1'b0, 1'b0);
        pop_chk("drain last", 8'h55, 1'b0, 1'b0);
        chk("drain empty", 32'(ifc.rx_empty), 32'd1);

        // Threshold and character timeout.
        ifc.irq_level = 5'd4;
        for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        step(); step();
        chk("below threshold irq", 32'(ifc.rx_irq), 32'd0);
        ticks(639);
        step(); step(); step();
        chk("timeout not yet", 32'(ifc.rx_timeout), 32'd0);
        ticks(1);
        step(); step(); step();
        chk("timeout set", 32'(ifc.rx_timeout), 32'd1);
        chk("timeout irq", 32'(ifc.rx_irq), 32'd1);
        $display("timeout: rx_timeout=%0b irq=%0b", ifc.rx_timeout, ifc.rx_irq);
        pop_chk("timeout pop", 8'h40, 1'b0, 1'b0);
        step();
        chk("timeout cleared by pop", 32'(ifc.rx_timeout), 32'd0);
        chk("irq after pop", 32'(ifc.rx_irq), 32'd0);
        send_byte(8'h50, 1'b0, 1'b0, 1'b0);
        send_byte(8'h51, 1'b0, 1'b0, 1'b0);
        step();
        chk("threshold count", 32'(ifc.fifo_count), 32'd4);
        chk("threshold irq", 32'(ifc.rx_irq), 32'd1);
        ifc.irq_level = 5'd5; step(); step();
        chk("threshold 5 irq", 32'(ifc.rx_irq), 32'd0);
        ifc.irq_level = 5'd0;

        // Reset in WAIT_STOP with 5 entries stored.
        send_byte(8'h52, 1'b0, 1'b0, 1'b0);
        chk("pre-reset count", 32'(ifc.fifo_count), 32'd5);
        ifc.rx_byte = 8'h99; ifc.rx_fifo_write_n = 1'b0; step(); step();
        ifc.rx_fifo_write_n = 1'b1;
        chk("pre-reset overflow", 32'(ifc.rx_overflow), 32'd1);
        reset_n = 1'b0;
        #2;
        chk_reset_vals("async");
        step(); step();
        reset_n = 1'b1;
        step();
        send_byte(8'h77, 1'b1, 1'b0, 1'b0);
        chk("post-reset count", 32'(ifc.fifo_count), 32'd1);
        pop_chk("post-reset", 8'h77, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo_ctrl.md
Name: uart_rx_fifo_ctrl

Overview:
- Sequences the asynchronous UART receiver and buffers its output for the APB register block.
- Captures each received byte and its parity flag on the receiver's active-low write strobe, then waits for the stop-bit phase to resolve the framing flag.
- Commits {framing, parity, byte} into an internal FIFO and issues the receiver's error-clear pulses.
- Provides bus-side pop, fill-level status, sticky overflow, and a threshold/character-timeout interrupt.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries of 10 bits.
- TIMEOUT_TICKS, 640, baud_clock ticks of idle with a non-empty FIFO before the timeout flag sets (4 characters × 10 bits × 16 ticks).
- STOP_WAIT_TICKS, 32, maximum baud ticks spent in WAIT_STOP before a forced commit.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- baud_clock  in  1  one-clk-wide 16x baud tick, shared with the receiver
- rx_fifo_write_n  in  1  active-low one-cycle byte-ready strobe from the receiver
- rx_byte  in  8  received data
- rx_parity_err  in  1  receiver parity error flag
- rx_framing_err  in  1  receiver framing error flag
- rx_stop_strobe  in  1  end-of-stop-bit pulse from the receiver
- rx_idle  in  1  receiver idle
- rx_clear_parity  out  1  parity clear pulse to the receiver
- rx_clear_framing_error  out  1  framing clear pulse to the receiver
- rd_req  in  1  pop request from the bus
- rd_data  out  8  popped byte
- rd_parity_err  out  1  parity flag of the popped entry
- rd_framing_err  out  1  framing flag of the popped entry
- rd_valid  out  1  rd_* outputs valid (one-cycle pulse)
- irq_level  in  DEPTH_LOG2+1  fill threshold; 0 disables the threshold term
- overflow_clr  in  1  clears rx_overflow
- fifo_count  out  DEPTH_LOG2+1  entries held
- rx_empty  out  1  fifo_count == 0
- rx_full  out  1  fifo_count == 2**DEPTH_LOG2
- rx_overflow  out  1  sticky overflow
- rx_timeout  out  1  sticky character timeout
- rx_irq  out  1  interrupt

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk.
- Reset values:
  - FSM in IDLE; FIFO empty with pointers at 0.
  - fifo_count=0, rx_empty=1, rx_full=0.
  - All other outputs 0, including rd_data.
- FSM states: IDLE, WAIT_STOP, COMMIT.
  - IDLE: when rx_fifo_write_n=0, latch rx_byte and rx_parity_err into staging, clear the staged framing bit and the stop-wait counter, go to WAIT_STOP.
  - WAIT_STOP: any clk with rx_framing_err=1 sets the staged framing bit (OR-accumulate). The stop-wait counter increments on baud_clock.
    - rx_stop_strobe=1 → COMMIT.
    - Counter reaches STOP_WAIT_TICKS → set the staged framing bit, go to COMMIT.
  - COMMIT (one clk):
    - If not full, or a pop occurs in the same clk: write the staged entry.
    - Otherwise: drop the entry and set rx_overflow.
    - Pulse rx_clear_parity and rx_clear_framing_error high for exactly this clk.
    - → IDLE.
- A write strobe arriving in WAIT_STOP or COMMIT is dropped, sets rx_overflow, and leaves staging untouched.
- Pop: rd_req with FIFO non-empty reads the head. Next clk: rd_data/rd_parity_err/rd_framing_err show the head and rd_valid=1 (latency 1). rd_data holds its value until the next pop.
- rd_req while empty is ignored: rd_valid stays 0 and no state changes.
- Commit and pop in the same clk:
  - When full: both happen, count unchanged, no overflow.
  - When empty: the write happens, the pop is ignored.
- Pointers wrap modulo 2**DEPTH_LOG2. fifo_count is updated in the same clk as the write/pop, so status is visible the next cycle.
- rx_overflow: set by a dropped entry; cleared by overflow_clr. A set in the same clk as a clear wins.
- Timeout counter:
  - Increments on baud_clock while FIFO non-empty, rx_idle=1 and FSM in IDLE.
  - Resets to 0 on commit, on pop, or when the FIFO is empty.
  - Reaching TIMEOUT_TICKS sets rx_timeout. rx_timeout clears on pop or when the FIFO goes empty; the counter saturates.
- rx_irq (registered) = (irq_level≠0 & fifo_count≥irq_level) | rx_timeout | rx_overflow.

Test Plan:
- Single byte: strobe with rx_byte=0xA5, parity=0, then rx_stop_strobe → one clk later fifo_count=1, clear pulses 1 clk wide. Then rd_req → rd_data=0xA5, rd_valid=1 next clk, fifo_count=0.
- Framing resolution: strobe 0x3C, assert rx_framing_err 2 clks before rx_stop_strobe → popped entry has rd_framing_err=1, rd_parity_err=0. With no stop strobe at all → forced commit after 32 baud ticks, framing=1.
- Overflow: DEPTH_LOG2=4, commit 17 bytes 0x00..0x10 with no reads → fifo_count=16, rx_full=1, rx_overflow=1, rx_irq=1. The 16 pops return 0x00..0x0F. overflow_clr → rx_overflow=0.
- Full with simultaneous pop: FIFO full, rd_req in the COMMIT clk → no overflow, count stays 16, and the last pop returns the new byte.
- Threshold/timeout: irq_level=4, commit 3 bytes → rx_irq=0. Keep rx_idle=1 for 640 baud ticks → rx_timeout=1, rx_irq=1. One pop → rx_timeout=0.
- Reset mid-operation: assert reset_n=0 in WAIT_STOP with 5 entries stored → all outputs at reset values, fifo_count=0, and the next byte is captured normally.
